// File: rtl/fbus_pkg.sv
// Shared bus definitions for the frame-buffer memory target: command codes,
// burst-length decode and target state encoding.
package fbus_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE    = 3'b000,
    CMD_WR_DATA = 3'b001,
    CMD_RD_REQ  = 3'b010,
    CMD_RD_DATA = 3'b011,
    CMD_WR_REQ  = 3'b100,
    CMD_WR_RESP = 3'b101,
    CMD_ERR     = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BID,
    ST_WR_RESP,
    ST_WR_DATA,
    ST_RD_BID,
    ST_RD_DATA
  } tgt_state_e;

  localparam logic [1:0] REQ_BID = 2'b11;

  function automatic logic [3:0] len_beats(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

endpackage

// File: rtl/fbmem_target_if.sv
// Bus-side signal bundle of fbmem_target; slave is the target view,
// master the bus/initiator view.
interface fbmem_target_if;
  logic        selin;
  logic [2:0]  cmdin;
  logic [1:0]  lenin;
  logic [31:0] addrdatain;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;

  modport slave (
    input  selin, cmdin, lenin, addrdatain, ackin,
    output reqout, reqtar, cmdout, lenout, addrdataout
  );

  modport master (
    output selin, cmdin, lenin, addrdatain, ackin,
    input  reqout, reqtar, cmdout, lenout, addrdataout
  );
endinterface

// File: rtl/fbmem_ram.sv
// Word storage for fbmem_target: one write port, one registered read port.
// Contents are deliberately not reset.
module fbmem_ram #(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);
  logic [31:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fbmem_target.sv
// Bus memory target: accepts write/read burst requests, bids for the bus,
// then streams response beats. Optional range check under FBMEM_TARGET_ERR_EN.
module fbmem_target
  import fbus_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter logic [31:0] BASE       = 32'h0001_0000,
  parameter logic [3:0]  INIT_ID    = 4'h1
) (
  input logic           clk,
  input logic           reset,
  fbmem_target_if.slave bus
);
`ifdef FBMEM_TARGET_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [31:0] WIN_BYTES = 32'd4 << DEPTH_LOG2;

  tgt_state_e            state, state_n;
  logic [31:0]           addr, addr_n, addr_inc;
  logic [1:0]            len, len_n;
  logic [3:0]            cnt, cnt_n;
  logic                  err, err_n;
  logic                  start_err, last_beat, we;
  logic [DEPTH_LOG2-1:0] waddr, raddr;
  logic [31:0]           rdata;

  assign addr_inc  = addr + 32'd4;
  assign waddr     = addr[DEPTH_LOG2+1:2];
  // While streaming, fetch one word ahead so the registered read keeps pace with the beats.
  assign raddr     = (state == ST_RD_DATA) ? addr_inc[DEPTH_LOG2+1:2] : addr[DEPTH_LOG2+1:2];
  assign last_beat = (cnt == (len_beats(len) - 4'd1));
  assign start_err = ERR_EN && ((bus.addrdatain - BASE) >= WIN_BYTES);

  fbmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.addrdatain),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      len   <= len_n;
      cnt   <= cnt_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    len_n   = len;
    cnt_n   = cnt;
    err_n   = err;
    we      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.selin && (bus.cmdin == CMD_WR_REQ || bus.cmdin == CMD_RD_REQ)) begin
          addr_n  = bus.addrdatain;
          len_n   = bus.lenin;
          cnt_n   = '0;
          err_n   = start_err;
          state_n = (bus.cmdin == CMD_WR_REQ) ? ST_WR_BID : ST_RD_BID;
        end
      end
      ST_WR_BID:  if (bus.ackin) state_n = ST_WR_RESP;
      ST_WR_RESP: state_n = ST_WR_DATA;
      ST_WR_DATA: begin
        if (bus.selin && bus.cmdin == CMD_WR_DATA) begin
          we     = !err;
          addr_n = addr_inc;
          cnt_n  = cnt + 4'd1;
          if (last_beat) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end
        end
      end
      ST_RD_BID:  if (bus.ackin) state_n = ST_RD_DATA;
      ST_RD_DATA: begin
        addr_n = addr_inc;
        cnt_n  = cnt + 4'd1;
        if (last_beat) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default:    state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.reqout      = '0;
    bus.reqtar      = '0;
    bus.cmdout      = CMD_IDLE;
    bus.lenout      = '0;
    bus.addrdataout = '0;
    case (state)
      ST_WR_BID, ST_RD_BID: begin
        bus.reqout = REQ_BID;
        bus.reqtar = INIT_ID;
      end
      ST_WR_RESP: begin
        bus.reqout = REQ_BID;
        bus.reqtar = INIT_ID;
        bus.cmdout = CMD_WR_RESP;
      end
      ST_RD_DATA: begin
        bus.reqout      = REQ_BID;
        bus.reqtar      = INIT_ID;
        bus.cmdout      = err ? CMD_ERR : CMD_RD_DATA;
        bus.lenout      = len;
        bus.addrdataout = err ? '0 : rdata;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fbmem_target.sv
// Randomized bench for fbmem_target: transaction-level memory model drives
// per-cycle expectations checked on every falling edge.
module tb_fbmem_target;
  localparam int unsigned DL    = 6;
  localparam int unsigned WORDS = 1 << DL;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [3:0]  ID    = 4'h1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  fbmem_target_if bus ();

  fbmem_target #(.DEPTH_LOG2(DL), .BASE(BASE), .INIT_ID(ID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        chk_en      = 1'b0;

  logic [1:0]  e_req;
  logic [3:0]  e_tar;
  logic [2:0]  e_cmd;
  logic [1:0]  e_len;
  logic [31:0] e_data;

  logic [31:0] mem_m  [WORDS];
  logic [31:0] wbuf   [8];
  logic [31:0] cap    [8];
  logic [2:0]  capcmd [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("reqout", 32'(bus.reqout), 32'(e_req));
      check("reqtar", 32'(bus.reqtar), 32'(e_tar));
      check("cmdout", 32'(bus.cmdout), 32'(e_cmd));
      check("lenout", 32'(bus.lenout), 32'(e_len));
      check("addrdataout", bus.addrdataout, e_data);
    end
  end

  function automatic int unsigned idx(input logic [31:0] a);
    return (a / 4) % WORDS;
  endfunction

  function automatic logic outside(input logic [31:0] a);
`ifdef FBMEM_TARGET_ERR_EN
    return !(a >= BASE && a < BASE + WORDS * 4);
`else
    return 1'b0;
`endif
  endfunction

  task automatic exp_idle();
    e_req = 2'b00; e_tar = 4'h0; e_cmd = 3'b000; e_len = 2'b00; e_data = '0;
  endtask

  task automatic exp_bid();
    exp_idle();
    e_req = 2'b11; e_tar = ID;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [2:0] cmd, input logic [1:0] len,
                       input logic [31:0] ad, input logic ack);
    bus.selin = sel; bus.cmdin = cmd; bus.lenin = len; bus.addrdatain = ad; bus.ackin = ack;
  endtask

  // Random traffic that the target must ignore; stall cycles never carry a data beat.
  task automatic junk(input bit stall);
    bus.selin      = 1'($urandom_range(1, 0));
    bus.cmdin      = 3'($urandom_range(5, 0));
    bus.lenin      = 2'($urandom_range(3, 0));
    bus.addrdatain = $urandom;
    bus.ackin      = 1'($urandom_range(1, 0));
    if (stall && bus.selin && bus.cmdin == 3'b001) bus.cmdin = 3'b010;
  endtask

  task automatic bid_phase(input int unsigned ackd);
    for (int unsigned i = 0; i <= ackd; i++) begin
      exp_bid();
      junk(1'b0);
      bus.ackin = (i == ackd);
      tick();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] len,
                          input int unsigned ackd, input int unsigned maxgap);
    int unsigned n   = 32'd1 << len;
    logic        err = outside(a);
    logic [31:0] ad  = a;
    exp_idle();
    drive(1'b1, 3'b100, len, a, 1'b0);
    tick();
    bid_phase(ackd);
    exp_bid();
    e_cmd = 3'b101;
    junk(1'b1);
    tick();
    for (int unsigned i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) begin
        exp_idle();
        junk(1'b1);
        tick();
      end
      exp_idle();
      drive(1'b1, 3'b001, 2'($urandom_range(3, 0)), wbuf[i], 1'($urandom_range(1, 0)));
      if (!err) mem_m[idx(ad)] = wbuf[i];
      ad = ad + 32'd4;
      tick();
    end
    exp_idle();
    drive(1'b0, 3'b000, 2'b00, '0, 1'b0);
  endtask

  // rst_at: beat index during which reset is pulsed (>= 8 means never).
  task automatic do_read(input logic [31:0] a, input logic [1:0] len,
                         input int unsigned ackd, input int unsigned rst_at);
    int unsigned n   = 32'd1 << len;
    logic        err = outside(a);
    logic [31:0] ad  = a;
    exp_idle();
    drive(1'b1, 3'b010, len, a, 1'b0);
    tick();
    bid_phase(ackd);
    for (int unsigned i = 0; i < n; i++) begin
      exp_bid();
      e_cmd  = err ? 3'b111 : 3'b011;
      e_len  = len;
      e_data = err ? '0 : mem_m[idx(ad)];
      junk(1'b0);
      cap[i]    = bus.addrdataout;
      capcmd[i] = bus.cmdout;
      if (i == rst_at) begin
        #2;
        reset = 1'b1;
        exp_idle();
        #1;
        check("rst_reqout", 32'(bus.reqout), 32'h0);
        check("rst_cmdout", 32'(bus.cmdout), 32'h0);
        check("rst_data", bus.addrdataout, 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b0, 3'b000, 2'b00, '0, 1'b0);
        return;
      end
      ad = ad + 32'd4;
      tick();
    end
    exp_idle();
    drive(1'b0, 3'b000, 2'b00, '0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 3'b000, 2'b00, '0, 1'b0);
    exp_idle();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed write then read-back of four words at indices 4..7.
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_write(BASE + 32'h10, 2'b10, 2, 0);
    do_read(BASE + 32'h10, 2'b10, 0, 99);
    check("rd4_cmd0", 32'(capcmd[0]), 32'h3);
    check("rd4_beat0", cap[0], 32'h11);
    check("rd4_beat1", cap[1], 32'h22);
    check("rd4_beat2", cap[2], 32'h33);
    check("rd4_beat3", cap[3], 32'h44);

    // Fill every word with a tag of its own index.
    for (int unsigned k = 0; k < WORDS / 8; k++) begin
      for (int unsigned j = 0; j < 8; j++) wbuf[j] = 32'hF000_0000 | (k * 8 + j);
      do_write(BASE + k * 32, 2'b11, k % 3, 1);
    end

    do_read(BASE + 32'd252, 2'b11, 1, 99);
    check("wrap_beat0", cap[0], 32'hF000_003F);
    check("wrap_beat1", cap[1], 32'hF000_0000);
    check("wrap_beat7", cap[7], 32'hF000_0006);

    do_read(BASE + 32'h1000, 2'b01, 0, 99);
`ifdef FBMEM_TARGET_ERR_EN
    check("oor_cmd0", 32'(capcmd[0]), 32'h7);
    check("oor_beat0", cap[0], 32'h0);
`else
    check("alias_beat0", cap[0], 32'hF000_0000);
    check("alias_beat1", cap[1], 32'hF000_0001);
`endif

    do_read(BASE + 32'h20, 2'b11, 1, 1);
    do_read(BASE + 32'h20, 2'b11, 0, 99);
    check("post_rst_beat0", cap[0], 32'hF000_0008);
    check("post_rst_beat7", cap[7], 32'hF000_000F);

    for (int unsigned t = 0; t < 150; t++) begin
      logic [31:0] a;
      logic [1:0]  len;
      if ($urandom_range(7, 0) == 0) a = $urandom;
      else a = BASE + $urandom_range(WORDS - 1, 0) * 4 + $urandom_range(3, 0);
      len = 2'($urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) begin
        for (int unsigned j = 0; j < 8; j++) wbuf[j] = $urandom;
        do_write(a, len, $urandom_range(3, 0), 2);
      end else begin
        do_read(a, len, $urandom_range(3, 0), 99);
      end
    end

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fbmem_target.md
FBMEM_TARGET -- requirements
Module: fbmem_target

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DEPTH_LOG2, 6, log2 of 32-bit word count; BASE, 32'h0001_0000, byte base address of window; INIT_ID, 4'h1, value driven on reqtar during responses.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
REQ-004 selin  in  1  this target selected for current bus command.
REQ-005 cmdin  in  3  bus command: 000 idle, 001 write data, 010 read request, 011 read data, 100 write request, 101 write response.
REQ-006 lenin  in  2  burst length code: 00=1, 01=2, 10=4, 11=8 beats.
REQ-007 addrdatain  in  32  byte address in request phase, data in data phase.
REQ-008 ackin  in  1  arbiter grant for this block's bid.
REQ-009 reqout  out  2  arbiter bid; 2'b11 while bidding or owning bus, else 2'b00.
REQ-010 reqtar  out  4  INIT_ID while reqout!=0, else 0.
REQ-011 cmdout  out  3  response command (101, 011 or 000; 111 only with macro).
REQ-012 lenout  out  2  echo of latched length code during read-data beats, else 0.
REQ-013 addrdataout  out  32  read data during 011 beats, else 0.

Function
REQ-014 States SHALL be IDLE, WR_BID, WR_RESP, WR_DATA, RD_BID, RD_DATA.
REQ-015 IDLE: selin=1 and cmdin=100 -> latch address/len, go WR_BID; selin=1 and cmdin=010 -> latch, go RD_BID; all other inputs ignored.
REQ-016 Commands arriving outside IDLE SHALL be ignored (no queueing).
REQ-017 WR_BID/RD_BID: reqout=2'b11 from the cycle after request until ackin=1 sampled; then WR_RESP or RD_DATA.
REQ-018 WR_RESP: one cycle cmdout=101, then WR_DATA with reqout=0.
REQ-019 WR_DATA: each cycle selin=1 and cmdin=001 writes addrdatain to the current word and advances address by 4; other cycles stall; exit to IDLE after the last beat.
REQ-020 RD_DATA: exactly N consecutive cycles with cmdout=011, addrdataout=mem[word], address +4 per beat; first beat in the cycle after ackin sampled; reqout drops to 0 in the cycle after the last beat, returning to IDLE.
REQ-021 Word index SHALL be address[DEPTH_LOG2+1:2]; bursts crossing the window top wrap modulo 2^DEPTH_LOG2.
REQ-022 Beat counter SHALL be 4 bits; address arithmetic SHALL be 32-bit modulo 2^32.
REQ-023 Memory SHALL have a synchronous read port; the first word SHALL be prefetched during RD_BID so beat 1 incurs no bubble.
REQ-024 Read-after-write to the same word in consecutive transactions SHALL return the new data.

Reset
REQ-025 reset=1 SHALL force IDLE, reqout=0, reqtar=0, cmdout=000, lenout=0, addrdataout=0, beat counter 0, asynchronously, including mid-burst; memory contents SHALL NOT be cleared.
REQ-026 After reset deasserts, the first request SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro FBMEM_TARGET_ERR_EN: when defined, a start address outside BASE..BASE+4*2^DEPTH_LOG2-1 SHALL produce N beats of cmdout=111 with addrdataout=0 for reads, and writes SHALL be acknowledged (101) but discarded; when undefined, no range check is performed and addresses alias per REQ-021.

Structure
REQ-028 Package fbus_pkg SHALL hold the cmd enum, len code decode function (code -> beat count), and target state enum.
REQ-029 Storage SHALL be one sub-module fbmem_ram (single write port, single synchronous read port, DEPTH_LOG2 parameter).

Verification
REQ-030 Write request to BASE+0x10, len 10, ackin after 2 cycles, data 11,22,33,44 -> one 101 cycle, four words stored at indices 4-7.
REQ-031 Read request to BASE+0x10, len 10, ackin same cycle as bid -> four consecutive 011 beats 11,22,33,44, lenout=10, then reqout=0.
REQ-032 Read, len 11, at last word (index 63) -> beats read indices 63,0,1,...,6 (wrap).
REQ-033 Assert reset during beat 2 of an 8-beat read -> all outputs 0 same cycle; new read after release completes normally.
REQ-034 Read request while in WR_DATA -> ignored; write completes, no read response.
REQ-035 With FBMEM_TARGET_ERR_EN, read at BASE+0x1000 len 01 -> two cycles cmdout=111, addrdataout=0; without the macro -> data from index 0,1.
